// File: rtl/fwd_stall_ctrl.sv
// fwd_stall_ctrl
// Pipeline hazard unit for a five-stage core. It chooses the bypass source
// for both decode operands and both execute operands, raises a stall when a
// decode operand would be needed before its producer can supply it, and
// keeps the multiply/divide unit busy for a fixed latency.
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   rs_D, rt_D                  decode source registers
//   tuse_rs_D, tuse_rt_D        cycles until decode needs each source
//                               (all-ones = never used)
//   rs_E, rt_E                  execute source registers
//   dst_E, dst_M, dst_W         destination register per stage (0 = none)
//   tnew_E, tnew_M              cycles until that stage's result exists
//   md_start_E, md_div_E        MDU issue from execute; divide qualifier
//   md_use_D                    decode touches HI/LO or starts the MDU
//   fwd_rs_D, fwd_rt_D          decode bypass: 0 regfile, 1 M, 2 W, 3 E
//   fwd_rs_E, fwd_rt_E          execute bypass: 0 pipe, 1 M, 2 W
//   stall                       freeze PC and IF/ID, bubble ID/EX
//   md_busy                     MDU countdown is non-zero
//   stall_cnt                   saturating count of stalled cycles
module fwd_stall_ctrl #(
  parameter int REG_AW  = 5,
  parameter int TW      = 2,
  parameter int LAT_MUL = 5,
  parameter int LAT_DIV = 10,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_D,
  input  logic [REG_AW-1:0] rt_D,
  input  logic [TW-1:0]     tuse_rs_D,
  input  logic [TW-1:0]     tuse_rt_D,
  input  logic [REG_AW-1:0] rs_E,
  input  logic [REG_AW-1:0] rt_E,
  input  logic [REG_AW-1:0] dst_E,
  input  logic [REG_AW-1:0] dst_M,
  input  logic [REG_AW-1:0] dst_W,
  input  logic [TW-1:0]     tnew_E,
  input  logic [TW-1:0]     tnew_M,
  input  logic              md_start_E,
  input  logic              md_div_E,
  input  logic              md_use_D,
  output logic [1:0]        fwd_rs_D,
  output logic [1:0]        fwd_rt_D,
  output logic [1:0]        fwd_rs_E,
  output logic [1:0]        fwd_rt_E,
  output logic              stall,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int MDW = $clog2(LAT_DIV + 1);
  localparam logic [MDW-1:0] MUL_LOAD = MDW'(LAT_MUL);
  localparam logic [MDW-1:0] DIV_LOAD = MDW'(LAT_DIV);

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_M  = 2'd1;
  localparam logic [1:0] SEL_W  = 2'd2;
  localparam logic [1:0] SEL_E  = 2'd3;

  // Operand index 0 = rs, 1 = rt for both stages.
  logic [REG_AW-1:0] src_d [2];
  logic [TW-1:0]     tuse_d [2];
  logic [REG_AW-1:0] src_e [2];
  logic [1:0]        fwd_d [2];
  logic [1:0]        fwd_e [2];
  logic [1:0]        hazard_d;

  assign src_d[0]  = rs_D;
  assign src_d[1]  = rt_D;
  assign tuse_d[0] = tuse_rs_D;
  assign tuse_d[1] = tuse_rt_D;
  assign src_e[0]  = rs_E;
  assign src_e[1]  = rt_E;

  // Results that already exist in their stage can be bypassed.
  logic e_ready;
  logic m_ready;
  assign e_ready = (tnew_E == '0);
  assign m_ready = (tnew_M == '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic hit_e_d, hit_m_d, hit_w_d;
      logic hit_m_e, hit_w_e;

      // Register 0 never matches: it is never written.
      assign hit_e_d = (dst_E != '0) && (src_d[gi] == dst_E);
      assign hit_m_d = (dst_M != '0) && (src_d[gi] == dst_M);
      assign hit_w_d = (dst_W != '0) && (src_d[gi] == dst_W);
      assign hit_m_e = (dst_M != '0) && (src_e[gi] == dst_M);
      assign hit_w_e = (dst_W != '0) && (src_e[gi] == dst_W);

      // A not-yet-ready value in a stage is only a problem if decode needs
      // the operand sooner than it will appear. The W stage is always ready.
      assign hazard_d[gi] = (hit_e_d && (tuse_d[gi] < tnew_E)) ||
                            (hit_m_d && (tuse_d[gi] < tnew_M));

      // Nearest producer wins. If that producer is not ready yet, older
      // copies further down the pipe are stale, so select the regfile and
      // let the stall (or a later cycle) cover it.
      assign fwd_d[gi] = hit_e_d ? (e_ready ? SEL_E : SEL_RF) :
                         hit_m_d ? (m_ready ? SEL_M : SEL_RF) :
                         hit_w_d ? SEL_W : SEL_RF;

      assign fwd_e[gi] = (hit_m_e && m_ready) ? SEL_M :
                         hit_w_e              ? SEL_W : SEL_RF;
    end
  endgenerate

  assign fwd_rs_D = fwd_d[0];
  assign fwd_rt_D = fwd_d[1];
  assign fwd_rs_E = fwd_e[0];
  assign fwd_rt_E = fwd_e[1];

  // MDU countdown. A start while already counting is dropped.
  logic [MDW-1:0] md_cnt_reg;
  logic [MDW-1:0] md_cnt_next;

  always_comb begin
    md_cnt_next = md_cnt_reg;
    if (md_start_E && (md_cnt_reg == '0)) begin
      md_cnt_next = md_div_E ? DIV_LOAD : MUL_LOAD;
    end else if (md_cnt_reg != '0) begin
      md_cnt_next = md_cnt_reg - 1'b1;
    end
  end

  assign md_busy = (md_cnt_reg != '0);

  // HI/LO users wait both for a running operation and for one issuing now.
  assign stall = (|hazard_d) || (md_use_D && (md_busy || md_start_E));

  // Stall counter saturates at all-ones.
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] stall_cnt_next;

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall && (stall_cnt_reg != '1)) begin
      stall_cnt_next = stall_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_reg    <= '0;
      stall_cnt_reg <= '0;
    end else begin
      md_cnt_reg    <= md_cnt_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Self-checking bench for fwd_stall_ctrl: directed scenarios followed by
// random traffic, all compared against a behavioural model of the hazard
// rules kept in this file.
module tb_fwd_stall_ctrl;

  localparam int REG_AW  = 5;
  localparam int TW      = 2;
  localparam int LAT_MUL = 5;
  localparam int LAT_DIV = 10;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] rs_D, rt_D, rs_E, rt_E, dst_E, dst_M, dst_W;
  logic [TW-1:0]     tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic              md_start_E, md_div_E, md_use_D;
  logic [1:0]        fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic              stall, md_busy;
  logic [CNT_W-1:0]  stall_cnt;

  fwd_stall_ctrl #(
    .REG_AW(REG_AW), .TW(TW), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .rs_E(rs_E), .rt_E(rt_E),
    .dst_E(dst_E), .dst_M(dst_M), .dst_W(dst_W),
    .tnew_E(tnew_E), .tnew_M(tnew_M),
    .md_start_E(md_start_E), .md_div_E(md_div_E), .md_use_D(md_use_D),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
    .stall(stall), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model state: remaining MDU cycles and stalled-cycle count.
  int m_cnt = 0;
  int m_sc  = 0;
  bit e_stall;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference: stages listed nearest first; W always has its result.
  function automatic int ref_fwd_d(input int src);
    int dsts[3];
    int tn[3];
    int code[3];
    dsts = '{int'(dst_E), int'(dst_M), int'(dst_W)};
    tn   = '{int'(tnew_E), int'(tnew_M), 0};
    code = '{3, 1, 2};
    for (int k = 0; k < 3; k++) begin
      if (dsts[k] != 0 && dsts[k] == src) return (tn[k] == 0) ? code[k] : 0;
    end
    return 0;
  endfunction

  function automatic bit ref_hazard(input int src, input int tuse);
    bit h = 0;
    if (dst_E != 0 && int'(dst_E) == src && tuse < int'(tnew_E)) h = 1;
    if (dst_M != 0 && int'(dst_M) == src && tuse < int'(tnew_M)) h = 1;
    return h;
  endfunction

  function automatic int ref_fwd_e(input int src);
    if (dst_M != 0 && int'(dst_M) == src && tnew_M == 0) return 1;
    if (dst_W != 0 && int'(dst_W) == src) return 2;
    return 0;
  endfunction

  task automatic idle_inputs();
    reset = 0;
    rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0;
    dst_E = 0; dst_M = 0; dst_W = 0;
    tuse_rs_D = '1; tuse_rt_D = '1; tnew_E = 0; tnew_M = 0;
    md_start_E = 0; md_div_E = 0; md_use_D = 0;
  endtask

  // Mid-cycle: compare every output with the model.
  task automatic sample(input string tag);
    #4;
    e_stall = ref_hazard(int'(rs_D), int'(tuse_rs_D)) ||
              ref_hazard(int'(rt_D), int'(tuse_rt_D)) ||
              (md_use_D && (m_cnt != 0 || md_start_E));
    check_value({tag, ":stall"},    32'(stall),    32'(e_stall));
    check_value({tag, ":fwd_rs_D"}, 32'(fwd_rs_D), 32'(ref_fwd_d(int'(rs_D))));
    check_value({tag, ":fwd_rt_D"}, 32'(fwd_rt_D), 32'(ref_fwd_d(int'(rt_D))));
    check_value({tag, ":fwd_rs_E"}, 32'(fwd_rs_E), 32'(ref_fwd_e(int'(rs_E))));
    check_value({tag, ":fwd_rt_E"}, 32'(fwd_rt_E), 32'(ref_fwd_e(int'(rt_E))));
    check_value({tag, ":md_busy"},  32'(md_busy),  32'(m_cnt != 0));
    check_value({tag, ":stall_cnt"}, 32'(stall_cnt), 32'(m_sc));
    $display("cyc %0d %s rst=%0b stall=%0b busy=%0b cnt=%0d fwdD=%0d/%0d fwdE=%0d/%0d",
             cyc, tag, reset, stall, md_busy, stall_cnt, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E);
  endtask

  // Clock edge, then advance the model with the inputs just applied.
  task automatic advance();
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_cnt = 0;
      m_sc  = 0;
    end else begin
      if (m_cnt > 0) m_cnt--;
      else if (md_start_E) m_cnt = md_div_E ? LAT_DIV : LAT_MUL;
      if (e_stall && m_sc < CNT_MAX) m_sc++;
    end
    #1;
  endtask

  task automatic step(input string tag);
    sample(tag);
    advance();
  endtask

  initial begin
    int busy_n;
    int stall_n;
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    m_cnt = 0; m_sc = 0;

    // Reset state
    step("reset");
    reset = 0;
    sample("post_reset");
    check_value("post_reset_busy", 32'(md_busy), 32'd0);
    check_value("post_reset_cnt", 32'(stall_cnt), 32'd0);
    advance();

    // Load-use: E produces r8 two cycles out, decode needs it next cycle
    dst_E = 8; tnew_E = 2; rs_D = 8; tuse_rs_D = 1;
    sample("load_use0");
    check_value("load_use_stall", 32'(stall), 32'd1);
    check_value("load_use_fwd", 32'(fwd_rs_D), 32'd0);
    advance();
    sample("load_use1");
    check_value("load_use_cnt1", 32'(stall_cnt), 32'd1);
    advance();
    sample("load_use2");
    check_value("load_use_cnt2", 32'(stall_cnt), 32'd2);
    advance();

    // Execute priority M over W, then W alone
    idle_inputs();
    rs_E = 3; dst_M = 3; tnew_M = 0; dst_W = 3;
    sample("ex_prio_m");
    check_value("ex_prio_m_sel", 32'(fwd_rs_E), 32'd1);
    advance();
    dst_M = 0;
    sample("ex_prio_w");
    check_value("ex_prio_w_sel", 32'(fwd_rs_E), 32'd2);
    advance();

    // Zero register never forwards
    idle_inputs();
    sample("zero_reg");
    check_value("zero_reg_fwd", 32'(fwd_rs_E), 32'd0);
    check_value("zero_reg_stall", 32'(stall), 32'd0);
    advance();

    // Divide: busy exactly LAT_DIV cycles, HI/LO user stalls start + LAT_DIV
    reset = 1; step("div_pre_reset"); reset = 0;
    md_start_E = 1; md_div_E = 1; md_use_D = 1;
    sample("div_start");
    busy_n  = md_busy ? 1 : 0;
    stall_n = stall ? 1 : 0;
    advance();
    for (int i = 1; i <= LAT_DIV + 2; i++) begin
      md_start_E = (i == 4);
      sample("div_run");
      if (md_busy) busy_n++;
      if (stall) stall_n++;
      advance();
    end
    check_value("div_busy_cycles", 32'(busy_n), 32'(LAT_DIV));
    check_value("div_stall_cycles", 32'(stall_n), 32'(LAT_DIV + 1));

    // Reset on the third busy cycle of a multiply aborts it
    idle_inputs();
    md_start_E = 1;
    step("mul_start");
    md_start_E = 0;
    step("mul_busy1");
    step("mul_busy2");
    reset = 1;
    sample("mul_busy3");
    check_value("mul_busy3_busy", 32'(md_busy), 32'd1);
    advance();
    reset = 0;
    sample("mul_abort");
    check_value("mul_abort_busy", 32'(md_busy), 32'd0);
    check_value("mul_abort_cnt", 32'(stall_cnt), 32'd0);
    advance();

    // Saturation after 20 stalled cycles
    dst_E = 8; tnew_E = 2; rs_D = 8; tuse_rs_D = 1;
    for (int i = 0; i < 20; i++) step("sat");
    sample("sat_end");
    check_value("sat_cnt", 32'(stall_cnt), 32'(CNT_MAX));
    advance();
    step("sat_hold");
    sample("sat_hold_end");
    check_value("sat_hold_cnt", 32'(stall_cnt), 32'(CNT_MAX));
    advance();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      reset      = ($urandom_range(0, 63) == 0);
      rs_D       = REG_AW'($urandom_range(0, 3));
      rt_D       = REG_AW'($urandom_range(0, 3));
      rs_E       = REG_AW'($urandom_range(0, 3));
      rt_E       = REG_AW'($urandom_range(0, 3));
      dst_E      = REG_AW'($urandom_range(0, 3));
      dst_M      = REG_AW'($urandom_range(0, 3));
      dst_W      = REG_AW'($urandom_range(0, 3));
      tuse_rs_D  = TW'($urandom_range(0, 3));
      tuse_rt_D  = TW'($urandom_range(0, 3));
      tnew_E     = TW'($urandom_range(0, 3));
      tnew_M     = TW'($urandom_range(0, 3));
      md_start_E = ($urandom_range(0, 7) == 0);
      md_div_E   = 1'($urandom_range(0, 1));
      md_use_D   = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fwd_stall_ctrl.md
FWD_STALL_CTRL -- requirements
Module: fwd_stall_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register-address width; address 0 is the hardwired zero register.
REQ-002 Parameter TW, default 2: width of every Tuse/Tnew field.
REQ-003 Parameter LAT_MUL, default 5: multiply busy cycles.
REQ-004 Parameter LAT_DIV, default 10: divide busy cycles.
REQ-005 Parameter CNT_W, default 16: stall-counter width.
REQ-006 Port clk, input, 1: the only clock; all state updates on the rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Ports rs_D and rt_D, input, REG_AW: source registers of the instruction in decode.
REQ-009 Ports tuse_rs_D and tuse_rt_D, input, TW: cycles until decode needs each source; all-ones means never used.
REQ-010 Ports rs_E and rt_E, input, REG_AW: source registers of the instruction in execute.
REQ-011 Ports dst_E, dst_M and dst_W, input, REG_AW: destination register per stage; 0 means no write.
REQ-012 Ports tnew_E and tnew_M, input, TW: cycles until that stage's result exists; W result is always ready.
REQ-013 Port md_start_E, input, 1: mult/div issues from execute this cycle.
REQ-014 Port md_div_E, input, 1: qualifies md_start_E; 1 = divide.
REQ-015 Port md_use_D, input, 1: decode instruction reads HI/LO or starts the MDU.
REQ-016 Ports fwd_rs_D and fwd_rt_D, output, 2: decode bypass select; 0 = regfile, 1 = M, 2 = W, 3 = E.
REQ-017 Ports fwd_rs_E and fwd_rt_E, output, 2: execute bypass select; 0 = regfile/pipe, 1 = M, 2 = W.
REQ-018 Port stall, output, 1: freeze PC and IF/ID and bubble ID/EX.
REQ-019 Port md_busy, output, 1: MDU countdown is non-zero.
REQ-020 Port stall_cnt, output, CNT_W: saturating count of stalled cycles.

Function
REQ-021 Define match(src, dst): true when dst != 0 and src == dst.
REQ-022 A decode source with match to stage X is a hazard when tuse_D < tnew_X, for X in {E, M}.
REQ-023 Drive stall = 1 on any hazard on rs_D or rt_D, or when md_use_D and (md_busy or md_start_E); otherwise 0.
REQ-024 Decode bypass per source, nearest first:
- E, only when tnew_E == 0: select 3.
- else M, only when tnew_M == 0: select 1.
- else W: select 2.
- else 0.
REQ-025 A nearer match with non-zero Tnew blocks all farther sources: select 0 (stall covers the hazard).
REQ-026 Execute bypass: M match with tnew_M == 0 -> 1; else W match -> 2; else 0; no match on register 0.
REQ-027 All bypass selects and stall are combinational from the current inputs and md_busy.
REQ-028 MDU countdown md_cnt, width clog2(LAT_DIV+1):
- When md_start_E and md_cnt == 0, load LAT_DIV if md_div_E, else LAT_MUL.
- Else when md_cnt != 0, decrement by 1.
- Else hold.
REQ-029 md_busy = (md_cnt != 0), driven from the register.
REQ-030 md_start_E while md_cnt != 0 is ignored; the count continues unchanged.
REQ-031 stall_cnt increments by 1 on each rising edge where stall == 1.
REQ-032 stall_cnt holds at all-ones once reached and never wraps.

Reset
REQ-033 Reset clears md_cnt and stall_cnt on the next rising edge, overriding a simultaneous md_start_E or stall.
REQ-034 In the cycle after reset, md_busy = 0 and stall_cnt = 0.
REQ-035 Combinational outputs track their inputs while reset is asserted.
REQ-036 Reset during an MDU countdown aborts it; md_busy = 0 on the next cycle.

Verification
REQ-037 Load-use: dst_E = 8, tnew_E = 2, rs_D = 8, tuse_rs_D = 1 -> stall = 1, fwd_rs_D = 0; stall_cnt +1 per cycle.
REQ-038 Execute priority: rs_E = 3, dst_M = 3, tnew_M = 0, dst_W = 3 -> fwd_rs_E = 1; with dst_M = 0 -> fwd_rs_E = 2.
REQ-039 Zero register: rs_E = 0, dst_M = 0, dst_W = 0 -> fwd_rs_E = 0, stall = 0.
REQ-040 Divide: md_start_E = 1, md_div_E = 1 -> md_busy = 1 for exactly 10 cycles.
- md_use_D held at 1 -> stall = 1 during the start cycle plus those 10 cycles.
- A second md_start_E mid-count is ignored.
REQ-041 Reset mid-multiply, asserted on the 3rd busy cycle -> md_busy = 0 and stall_cnt = 0 on the following cycle.
REQ-042 Saturation: CNT_W = 4, stall held for 20 cycles -> stall_cnt reads 15 and stays at 15.
